// File: rtl/scalar_pkg.sv
// Shared types and constants for the scalar operand-fetch slice.
// Optional execute-stage forwarding is enabled by defining SCALAR_EXEC_FWD_EN.
package scalar_pkg;

    localparam int NREGS     = 32;
    localparam int DATA_W    = 36;
    localparam int IMM_W     = 25;
    localparam int OP_W      = 5;
    localparam int REG_IDX_W = $clog2(NREGS);

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9,
        ALU_MOV  = 5'd10
    } alu_op_t;

    // The opcode is carried as raw bits so undecoded values pass through untouched.
    typedef struct packed {
        logic [DATA_W-1:0]    data1;
        logic [DATA_W-1:0]    data2;
        logic [IMM_W-1:0]     imm;
        logic [OP_W-1:0]      alu_op;
        logic                 alu_operands;
        logic [REG_IDX_W-1:0] rd;
        logic                 wr_en;
    } operand_bundle_t;

endpackage

// File: rtl/scalar_scoreboard.sv
// Pending-write scoreboard: one bit per scalar register, set on issue, cleared on writeback.
module scalar_scoreboard
    import scalar_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    output logic                 pend_rs1,
    output logic                 pend_rs2,
    output logic                 pend_rd
);

    logic [NREGS-1:0] pending;

    // The set is written last so a same-cycle issue to a retiring register keeps it pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (clr_en) pending[clr_idx] <= 1'b0;
            if (set_en) pending[set_idx] <= 1'b1;
        end
    end

    assign pend_rs1 = pending[rs1];
    assign pend_rs2 = pending[rs2];
    assign pend_rd  = pending[rd];

endmodule

// File: rtl/scalar_operand_fetch.sv
// Operand fetch/issue stage: register file, hazard stall, writeback bypass, output register.
// Define SCALAR_EXEC_FWD_EN to add the execute-stage forwarding path.
module scalar_operand_fetch
    import scalar_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_wr_en,
    input  logic                 in_use_imm,
    input  logic [IMM_W-1:0]     in_imm,
    input  logic [OP_W-1:0]      in_alu_op,
`ifdef SCALAR_EXEC_FWD_EN
    input  logic                 ex_fwd_valid,
    input  logic [REG_IDX_W-1:0] ex_fwd_rd,
    input  logic [DATA_W-1:0]    ex_fwd_data,
`endif
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    data1,
    output logic [DATA_W-1:0]    data2,
    output logic [IMM_W-1:0]     imm,
    output logic [OP_W-1:0]      alu_op,
    output logic                 alu_operands,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_wr_en
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wb_wr, wb_hit1, wb_hit2, wb_hit_rd;
    logic              fwd_hit1, fwd_hit2;
    logic              pend_rs1, pend_rs2, pend_rd;
    logic              stall, accept;
    logic [DATA_W-1:0] op1, op2;
    operand_bundle_t   next_b, out_q;
    logic              out_valid_q;

    assign wb_wr     = wb_en && (wb_rd != '0);
    assign wb_hit1   = wb_wr && (wb_rd == in_rs1);
    assign wb_hit2   = wb_wr && (wb_rd == in_rs2);
    assign wb_hit_rd = wb_wr && (wb_rd == in_rd);

`ifdef SCALAR_EXEC_FWD_EN
    assign fwd_hit1 = ex_fwd_valid && (ex_fwd_rd == in_rs1) && (in_rs1 != '0);
    assign fwd_hit2 = ex_fwd_valid && (ex_fwd_rd == in_rs2) && (in_rs2 != '0);
`else
    assign fwd_hit1 = 1'b0;
    assign fwd_hit2 = 1'b0;
`endif

    // Later assignments take priority: writeback over execute forward over register file.
    always_comb begin
        op1 = (in_rs1 == '0) ? '0 : regs[in_rs1];
        op2 = (in_rs2 == '0) ? '0 : regs[in_rs2];
`ifdef SCALAR_EXEC_FWD_EN
        if (fwd_hit1) op1 = ex_fwd_data;
        if (fwd_hit2) op2 = ex_fwd_data;
`endif
        if (wb_hit1) op1 = wb_data;
        if (wb_hit2) op2 = wb_data;
    end

    // A pending bit being retired this very cycle no longer counts as a hazard.
    assign stall = (pend_rs1 && !wb_hit1 && !fwd_hit1)
                || (!in_use_imm && pend_rs2 && !wb_hit2 && !fwd_hit2)
                || (in_wr_en && pend_rd && !wb_hit_rd);

    assign in_ready = !rst && !stall && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    scalar_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept && in_wr_en && (in_rd != '0)),
        .set_idx  (in_rd),
        .clr_en   (wb_wr),
        .clr_idx  (wb_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .rd       (in_rd),
        .pend_rs1 (pend_rs1),
        .pend_rs2 (pend_rs2),
        .pend_rd  (pend_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_wr) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        next_b              = '0;
        next_b.data1        = op1;
        next_b.data2        = op2;
        next_b.imm          = in_imm;
        next_b.alu_op       = in_alu_op;
        next_b.alu_operands = in_use_imm;
        next_b.rd           = in_rd;
        next_b.wr_en        = in_wr_en;
    end

    // Fields are only reloaded on accept, so a held bundle stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= next_b;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign data1        = out_q.data1;
    assign data2        = out_q.data2;
    assign imm          = out_q.imm;
    assign alu_op       = out_q.alu_op;
    assign alu_operands = out_q.alu_operands;
    assign out_rd       = out_q.rd;
    assign out_wr_en    = out_q.wr_en;

endmodule

// File: tb/tb_scalar_operand_fetch.sv
// Vector-table bench for scalar_operand_fetch with a queue of expected operand bundles.
// Define SCALAR_EXEC_FWD_EN to also exercise the execute forwarding path.
module tb_scalar_operand_fetch;
    import scalar_pkg::*;

    typedef struct {
        logic        in_valid;
        logic [4:0]  rs1, rs2, rd;
        logic        wr_en, use_imm;
        logic [24:0] imm;
        logic [4:0]  alu_op;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [35:0] wb_data;
        logic        fwd_valid;
        logic [4:0]  fwd_rd;
        logic [35:0] fwd_data;
        logic        out_ready;
        logic        exp_ready;
        logic        exp_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_wr_en, in_use_imm;
    logic [24:0] in_imm;
    logic [4:0]  in_alu_op;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [35:0] wb_data;
    logic        out_valid, out_ready;
    logic [35:0] data1, data2;
    logic [24:0] imm;
    logic [4:0]  alu_op;
    logic        alu_operands;
    logic [4:0]  out_rd;
    logic        out_wr_en;
`ifdef SCALAR_EXEC_FWD_EN
    logic        ex_fwd_valid;
    logic [4:0]  ex_fwd_rd;
    logic [35:0] ex_fwd_data;
`endif

    int checks   = 0;
    int failures = 0;
    logic [35:0]     mregs [32];
    operand_bundle_t expq [$];
    vec_t            tbl [$];

    always #5 clk = ~clk;

    scalar_operand_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_wr_en     (in_wr_en),
        .in_use_imm   (in_use_imm),
        .in_imm       (in_imm),
        .in_alu_op    (in_alu_op),
`ifdef SCALAR_EXEC_FWD_EN
        .ex_fwd_valid (ex_fwd_valid),
        .ex_fwd_rd    (ex_fwd_rd),
        .ex_fwd_data  (ex_fwd_data),
`endif
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data1        (data1),
        .data2        (data2),
        .imm          (imm),
        .alu_op       (alu_op),
        .alu_operands (alu_operands),
        .out_rd       (out_rd),
        .out_wr_en    (out_wr_en)
    );

    function automatic vec_t idle(input logic rdy, input logic vld);
        vec_t v;
        v = '{default: '0};
        v.out_ready = 1'b1;
        v.exp_ready = rdy;
        v.exp_valid = vld;
        return v;
    endfunction

    function automatic vec_t iss(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic wr, input logic sel,
                                 input logic rdy, input logic vld);
        vec_t v;
        v          = idle(rdy, vld);
        v.in_valid = 1'b1;
        v.rs1      = rs1;
        v.rs2      = rs2;
        v.rd       = rd;
        v.wr_en    = wr;
        v.use_imm  = sel;
        v.imm      = 25'h0A5A5A ^ (25'(rd) << 12) ^ 25'(rs1);
        v.alu_op   = rs1 ^ rd;
        return v;
    endfunction

    function automatic vec_t with_wb(input vec_t vi, input logic [4:0] r, input logic [35:0] d);
        vec_t v;
        v         = vi;
        v.wb_en   = 1'b1;
        v.wb_rd   = r;
        v.wb_data = d;
        return v;
    endfunction

    function automatic vec_t with_fwd(input vec_t vi, input logic [4:0] r, input logic [35:0] d);
        vec_t v;
        v           = vi;
        v.fwd_valid = 1'b1;
        v.fwd_rd    = r;
        v.fwd_data  = d;
        return v;
    endfunction

    function automatic vec_t held(input vec_t vi);
        vec_t v;
        v           = vi;
        v.out_ready = 1'b0;
        return v;
    endfunction

    function automatic logic [35:0] model_op(input logic [4:0] s, input vec_t v);
        if (v.wb_en && v.wb_rd == s && s != 5'd0) return v.wb_data;
`ifdef SCALAR_EXEC_FWD_EN
        if (v.fwd_valid && v.fwd_rd == s && s != 5'd0) return v.fwd_data;
`endif
        if (s == 5'd0) return 36'd0;
        return mregs[s];
    endfunction

    task automatic check1(input string name, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkBundle(input string name, input operand_bundle_t exp);
        operand_bundle_t got;
        got = '{data1: data1, data2: data2, imm: imm, alu_op: alu_op,
                alu_operands: alu_operands, rd: out_rd, wr_en: out_wr_en};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got d1=%h d2=%h imm=%h op=%h sel=%b rd=%0d we=%b expected d1=%h d2=%h imm=%h op=%h sel=%b rd=%0d we=%b",
                     name, got.data1, got.data2, got.imm, got.alu_op, got.alu_operands, got.rd, got.wr_en,
                     exp.data1, exp.data2, exp.imm, exp.alu_op, exp.alu_operands, exp.rd, exp.wr_en);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid   = v.in_valid;
        in_rs1     = v.rs1;
        in_rs2     = v.rs2;
        in_rd      = v.rd;
        in_wr_en   = v.wr_en;
        in_use_imm = v.use_imm;
        in_imm     = v.imm;
        in_alu_op  = v.alu_op;
        wb_en      = v.wb_en;
        wb_rd      = v.wb_rd;
        wb_data    = v.wb_data;
        out_ready  = v.out_ready;
`ifdef SCALAR_EXEC_FWD_EN
        ex_fwd_valid = v.fwd_valid;
        ex_fwd_rd    = v.fwd_rd;
        ex_fwd_data  = v.fwd_data;
`endif
    endtask

    // Runs one cycle: checks handshake and held bundle, then updates the reference model.
    task automatic checkOutput(input string name, input vec_t v);
        operand_bundle_t e;
        #1;
        check1({name, ".in_ready"}, 36'(in_ready), 36'(v.exp_ready));
        check1({name, ".out_valid"}, 36'(out_valid), 36'(v.exp_valid));
        if (v.exp_valid) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s.bundle: got out_valid with no expected bundle queued", name);
            end else begin
                checkBundle({name, ".bundle"}, expq[0]);
                if (v.out_ready) void'(expq.pop_front());
            end
        end
        if (v.in_valid && v.exp_ready) begin
            e = '{data1: model_op(v.rs1, v), data2: model_op(v.rs2, v), imm: v.imm,
                  alu_op: v.alu_op, alu_operands: v.use_imm, rd: v.rd, wr_en: v.wr_en};
            expq.push_back(e);
        end
        @(posedge clk);
        if (v.wb_en && v.wb_rd != 5'd0) mregs[v.wb_rd] = v.wb_data;
        @(negedge clk);
    endtask

    // Drives one reset cycle and checks that every output is cleared.
    task automatic resetCycle(input string name, input vec_t v);
        applyStimulus(v);
        rst = 1'b1;
        #1;
        check1({name, ".in_ready"}, 36'(in_ready), 36'd0);
        @(posedge clk);
        #1;
        check1({name, ".out_valid"}, 36'(out_valid), 36'd0);
        checkBundle({name, ".fields"}, '0);
        expq.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 36'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 32; i++) mregs[i] = 36'd0;

        tbl.push_back(with_wb(iss(5, 0, 0, 0, 0, 1, 0), 3, 36'h0_0000_00AB));
        tbl.push_back(iss(3, 0, 1, 0, 0, 1, 1));
        v = iss(0, 3, 7, 1, 1, 1, 1);
        v.imm    = '1;
        v.alu_op = 5'd31;
        tbl.push_back(v);
        tbl.push_back(iss(7, 0, 2, 1, 0, 0, 1));
        tbl.push_back(iss(7, 0, 2, 1, 0, 0, 0));
        tbl.push_back(with_wb(iss(7, 0, 2, 1, 0, 1, 0), 7, 36'h123));
        tbl.push_back(iss(0, 2, 0, 0, 0, 0, 1));
        tbl.push_back(iss(3, 2, 0, 1, 1, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(held(iss(3, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(iss(3, 0, 0, 0, 0, 1, 1));
        tbl.push_back(iss(0, 0, 4, 1, 0, 1, 1));
        tbl.push_back(with_wb(iss(0, 0, 4, 1, 0, 1, 1), 4, 36'h77));
        tbl.push_back(iss(4, 0, 0, 0, 0, 0, 1));
        tbl.push_back(iss(4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(with_wb(iss(4, 0, 0, 0, 0, 1, 0), 4, 36'h999));
        tbl.push_back(idle(1, 1));
        tbl.push_back(iss(0, 0, 2, 1, 0, 0, 0));
        tbl.push_back(with_wb(iss(0, 0, 2, 0, 0, 1, 0), 0, 36'hFFF));
        tbl.push_back(idle(1, 1));
        tbl.push_back(idle(1, 0));

        resetCycle("reset", idle(0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d", i), tbl[i]);
        end

        v = held(iss(3, 0, 5, 1, 0, 1, 0));
        applyStimulus(v);
        checkOutput("midrst_issue", v);
        v = held(idle(0, 1));
        applyStimulus(v);
        checkOutput("midrst_hold", v);
        resetCycle("midrst_reset", held(iss(5, 0, 0, 0, 0, 0, 0)));
        v = iss(5, 2, 2, 1, 0, 1, 0);
        applyStimulus(v);
        checkOutput("post_rst_sb", v);
        v = iss(3, 0, 0, 0, 0, 1, 1);
        applyStimulus(v);
        checkOutput("post_rst_rf", v);
        v = idle(1, 1);
        applyStimulus(v);
        checkOutput("post_rst_drain", v);

`ifdef SCALAR_EXEC_FWD_EN
        v = iss(0, 0, 9, 1, 0, 1, 0);
        applyStimulus(v);
        checkOutput("fwd_setup", v);
        v = with_fwd(iss(0, 9, 0, 0, 0, 1, 1), 9, 36'h55);
        applyStimulus(v);
        checkOutput("fwd_rs2", v);
        v = with_wb(with_fwd(iss(9, 0, 0, 0, 0, 1, 1), 9, 36'h55), 9, 36'h66);
        applyStimulus(v);
        checkOutput("fwd_wb_prio", v);
        v = with_fwd(iss(0, 0, 2, 1, 0, 0, 1), 2, 36'h11);
        applyStimulus(v);
        checkOutput("fwd_waw", v);
        v = idle(1, 0);
        applyStimulus(v);
        checkOutput("fwd_drain", v);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scalar_operand_fetch.md
Name: scalar_operand_fetch

Overview:
- Operand-fetch/issue stage that produces the operand bundle consumed by the scalar execute stage: data1, data2, raw 25-bit immediate, ALU op, operand-select, plus destination info.
- Owns the 32 x 36-bit scalar register file and a pending-write scoreboard.
- Stalls on RAW/WAW hazards and bypasses same-cycle writeback.
- Valid/ready handshake on both sides; one output pipeline register.

Parameters:
- NREGS, 32, number of scalar registers; register 0 reads zero and is never written.
- DATA_W, 36, scalar datapath width.
- IMM_W, 25, immediate width; passed raw, sign-extended downstream.
- OP_W, 5, ALU opcode width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_rs1, in_rs2, in_rd  in  5 each  source/destination register indices
- in_wr_en  in  1  instruction writes in_rd
- in_use_imm  in  1  second operand is immediate
- in_imm  in  IMM_W  raw immediate
- in_alu_op  in  OP_W  ALU operation
- wb_en  in  1  writeback strobe
- wb_rd  in  5  writeback index
- wb_data  in  DATA_W  writeback value
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute consumes bundle
- data1, data2  out  DATA_W  source operands
- imm  out  IMM_W  immediate
- alu_op  out  OP_W  ALU op
- alu_operands  out  1  copy of in_use_imm
- out_rd  out  5  destination index
- out_wr_en  out  1  destination write enable

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0; all output fields 0.
  - Scoreboard cleared; register file zeroed.
  - in_ready=0 during the reset cycle.
- Writeback:
  - On wb_en with wb_rd!=0, reg[wb_rd]<=wb_data and pending[wb_rd] cleared at the clock edge.
  - wb_rd==0 is ignored.
- Operand read with bypass: for each source s, if wb_en && wb_rd==s && s!=0, use wb_data; else if s==0, use 0; else use reg[s].
- Hazard stall, where a pending bit is ignored if the same-cycle wb clears it:
  - RAW: rs1 pending, or rs2 pending with in_use_imm==0.
  - WAW: in_wr_en && in_rd pending.
- Handshake:
  - in_ready = !stall && (!out_valid || out_ready).
  - Accepting an instruction loads the output register next cycle, so latency is 1 cycle.
  - On accept with in_wr_en && in_rd!=0, set pending[in_rd].
  - If wb clears and issue sets the same register in one cycle, set wins and the register stays pending.
- Output hold:
  - While out_valid && !out_ready, all outputs stay stable.
  - If out_ready with no new accept, out_valid drops to 0.
- Back-to-back: with out_ready=1 and no hazards, one instruction per cycle is accepted.
- Reset mid-stall or with out_valid=1: the bundle is discarded and the scoreboard cleared. No partial state survives.

Optional Feature:
- Macro: SCALAR_EXEC_FWD_EN.
- With the macro defined:
  - Adds inputs ex_fwd_valid (1), ex_fwd_rd (5), ex_fwd_data (DATA_W) from the execute output.
  - A RAW hazard on a register matching a valid ex_fwd_rd does not stall; ex_fwd_data is used.
  - Priority: wb bypass, then ex forward, then register file. Writeback wins if both match.
  - WAW still stalls.
- Without the macro: ports are absent and the block behaves exactly as described above.

Decomposition:
- Shared package scalar_pkg:
  - constants DATA_W, IMM_W, OP_W, NREGS, REG_IDX_W;
  - alu_op_t enum;
  - operand bundle struct (data1, data2, imm, alu_op, alu_operands, rd, wr_en).
- One sub-module, scalar_scoreboard:
  - NREGS pending bits with set/clear ports;
  - set-wins priority;
  - combinational pending lookups for rs1, rs2 and rd.

Test Plan:
- Reset → out_valid=0, in_ready=0 in the reset cycle; in_ready=1 on the next cycle. A read of r5 returns 0.
- wb r3=36'h0_0000_00AB, then issue add rs1=3 rs2=0 → next cycle data1=0xAB, data2=0, out_valid=1.
- Issue wr r7, then issue rs1=7 → second instruction stalls (in_ready=0) until wb_en rd=7 data=0x123. In that wb cycle it is accepted with data1=0x123 via bypass.
- out_ready=0 for 3 cycles with out_valid=1 → outputs unchanged, in_ready=0. Raise out_ready → next bundle appears the following cycle.
- Issue wr r4 while wb clears r4 in the same cycle → pending[r4] remains set. A later rs1=4 stalls.
- SCALAR_EXEC_FWD_EN: ex_fwd_valid=1 rd=9 data=0x55 while r9 pending, issue rs2=9 → no stall, data2=0x55.
